// File: rtl/stream_accumulator.sv
// Frame accumulator for the ripple-carry adder output stream.
// Sums COUNT accepted beats, then holds the total with a sticky overflow flag until the consumer takes it.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | empty frame: acc=0, beat_cnt=0; the first beat loads acc
// ACCUM | frame in progress; each accepted beat adds to acc
// HOLD  | total presented on out_*; no beats accepted until out_ready
module stream_accumulator #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic             in_cin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [3:0]       beat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(COUNT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [3:0]       cnt_q;
    logic             accept;
    logic             last_beat;
    logic             hold_done;
    logic [ACC_W:0]   sum_next;

    assign accept    = in_valid & in_ready;
    // The beat being accepted is the COUNT-th of the frame.
    assign last_beat = (cnt_q == LAST_CNT);
    assign hold_done = (state_q == HOLD) & out_ready;

    // One spare bit catches the carry out of the accumulator. acc is zero in IDLE,
    // so the same adder covers the first beat of a frame.
    assign sum_next = {1'b0, acc_q}
                    + {{(ACC_W + 1 - WIDTH){1'b0}}, in_a}
                    + {{ACC_W{1'b0}}, in_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = last_beat ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept && last_beat) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (state_q != HOLD) begin
            in_ready = ~abort;
        end
        if (state_q == HOLD) begin
            out_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (abort || hold_done) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= sum_next[ACC_W-1:0];
            ovf_q <= ovf_q | sum_next[ACC_W];
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign out_sum  = acc_q;
    assign out_ovf  = ovf_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench for stream_accumulator: directed frames push their expected totals,
// and a monitor pops and compares on every output handshake.
module tb_stream_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic       in_cin;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sum;
    logic       out_ovf;
    logic [3:0] beat_cnt;

    int checks   = 0;
    int failures = 0;
    int frames_seen = 0;

    typedef struct packed {
        logic [5:0] sum;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];

    stream_accumulator #(.WIDTH(4), .COUNT(4), .ACC_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_cin    (in_cin),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expect_frame(input logic [5:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Present one beat, confirm it will be taken, and step past the accepting edge.
    task automatic beat(input logic [3:0] a, input logic c);
        in_valid = 1'b1;
        in_a     = a;
        in_cin   = c;
        @(negedge clk);
        check("in_ready_before_beat", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got sum %0d ovf %0d, expected no frame (t=%0t)",
                         out_sum, out_ovf, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_sum", 32'(out_sum), 32'(e.sum));
                check("frame_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        bit gap_pat[6];
        int gap_cnt[6];
        gap_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gap_cnt = '{1, 1, 2, 3, 3, 4};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_cin    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;

        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum",   32'(out_sum),   32'd0);
        check("reset_out_ovf",   32'(out_ovf),   32'd0);
        check("reset_beat_cnt",  32'(beat_cnt),  32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        #9;
        rst_n = 1'b1;
        step();

        // Basic frame: 3+1+15+9+1 = 29
        expect_frame(6'd29, 1'b0);
        beat(4'd3, 1'b0);
        beat(4'd1, 1'b0);
        beat(4'd15, 1'b0);
        beat(4'd9, 1'b1);
        check("basic_out_valid", 32'(out_valid), 32'd1);
        check("basic_out_sum",   32'(out_sum),   32'd29);
        check("basic_beat_cnt",  32'(beat_cnt),  32'd4);
        check("basic_in_ready",  32'(in_ready),  32'd0);
        step();
        check("basic_idle_valid", 32'(out_valid), 32'd0);
        check("basic_idle_cnt",   32'(beat_cnt),  32'd0);
        check("basic_idle_ready", 32'(in_ready),  32'd1);

        // Overflow: 4 x 16 = 64 wraps to 0 with ovf set
        expect_frame(6'd0, 1'b1);
        for (int i = 0; i < 4; i++) beat(4'd15, 1'b1);
        check("ovf_out_sum", 32'(out_sum), 32'd0);
        check("ovf_out_ovf", 32'(out_ovf), 32'd1);
        step();
        check("ovf_cleared", 32'(out_ovf), 32'd0);
        expect_frame(6'd4, 1'b0);
        for (int i = 0; i < 4; i++) beat(4'd1, 1'b0);
        check("post_ovf_sum", 32'(out_sum), 32'd4);
        check("post_ovf_ovf", 32'(out_ovf), 32'd0);
        step();

        // Backpressure: total held while out_ready is low, extra beats refused
        expect_frame(6'd8, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(4'd2, 1'b0);
        in_valid = 1'b1;
        in_a     = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum",   32'(out_sum),   32'd8);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_beat_cnt",  32'(beat_cnt),  32'd4);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_cnt",   32'(beat_cnt),  32'd0);

        // Gapped input: only valid cycles count
        expect_frame(6'd20, 1'b0);
        in_a   = 4'd5;
        in_cin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = gap_pat[i];
            step();
            check("gap_beat_cnt", 32'(beat_cnt), 32'(gap_cnt[i]));
        end
        in_valid = 1'b0;
        check("gap_out_valid", 32'(out_valid), 32'd1);
        check("gap_out_sum",   32'(out_sum),   32'd20);
        step();

        // Abort wins over a simultaneous beat
        beat(4'd7, 1'b0);
        beat(4'd7, 1'b0);
        check("pre_abort_sum", 32'(out_sum), 32'd14);
        in_valid = 1'b1;
        in_a     = 4'd9;
        abort    = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_beat_cnt", 32'(beat_cnt), 32'd0);
        check("abort_acc",      32'(out_sum),  32'd0);
        check("abort_valid",    32'(out_valid), 32'd0);
        expect_frame(6'd10, 1'b0);
        beat(4'd1, 1'b0);
        beat(4'd2, 1'b0);
        beat(4'd3, 1'b0);
        beat(4'd4, 1'b0);
        check("post_abort_sum", 32'(out_sum), 32'd10);
        step();

        // Async reset mid-frame, between edges
        beat(4'd6, 1'b1);
        beat(4'd6, 1'b1);
        check("pre_reset_cnt", 32'(beat_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_out_sum",   32'(out_sum),   32'd0);
        check("areset_out_ovf",   32'(out_ovf),   32'd0);
        check("areset_beat_cnt",  32'(beat_cnt),  32'd0);
        @(posedge clk);
        #2;
        check("areset_held_cnt", 32'(beat_cnt), 32'd0);
        rst_n = 1'b1;
        expect_frame(6'd16, 1'b0);
        for (int i = 0; i < 4; i++) beat(4'd4, 1'b0);
        check("post_reset_sum", 32'(out_sum), 32'd16);
        step();

        repeat (4) step();
        check("frames_seen",   32'(frames_seen),  32'd7);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Sequential accumulator that sits directly downstream of the combinational 4-bit ripple-carry adder.
- Accepts a stream of operand/carry-in beats over a valid/ready handshake and sums exactly COUNT beats per frame into a wider accumulator.
- Presents the frame total, with a sticky overflow flag, on a valid/ready output port.
- Converts single-cycle add results into framed, flow-controlled totals for the next datapath stage.

Parameters:
- WIDTH, 4, operand width per beat (matches adder sum width).
- COUNT, 4, beats per frame; legal range 1..15.
- ACC_W, 6, accumulator width; must be >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  operand (adder sum).
- in_cin  input  1  extra +1 (adder carry-out), added as LSB weight.
- abort  input  1  synchronous frame flush.
- out_valid  output  1  frame total available.
- out_ready  input  1  consumer accepts total.
- out_sum  output  ACC_W  frame total, modulo 2^ACC_W.
- out_ovf  output  1  sticky: some accumulation in the frame exceeded 2^ACC_W-1.
- beat_cnt  output  4  beats accepted in current frame.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, immediate, independent of clk):
  - state=IDLE; acc=0; out_sum=0; out_ovf=0; out_valid=0; beat_cnt=0.
  - in_ready=1 once state is IDLE and abort is low.
  - No beat is accepted while rst_n is low.
- Beat acceptance: accept = in_valid & in_ready at the rising edge.
- Combinational output: in_ready = (state!=HOLD) & ~abort.
- Arithmetic per accepted beat:
  - Compute sum_next = acc + zero-extended in_a + in_cin in ACC_W+1 bits.
  - acc <= sum_next[ACC_W-1:0].
  - If sum_next[ACC_W]=1, ovf <= 1. ovf is sticky until the frame ends.
- States:
  - IDLE: acc=0, beat_cnt=0. An accepted beat loads acc=in_a+in_cin, beat_cnt=1, and moves to ACCUM. If COUNT==1, it moves to HOLD instead.
  - ACCUM: each accepted beat accumulates and increments beat_cnt. When the accepted beat makes beat_cnt==COUNT, move to HOLD. No accept means hold all state.
  - HOLD: out_valid=1; out_sum and out_ovf are stable and equal acc and ovf; in_ready=0. When out_valid & out_ready, the next state is IDLE and acc, ovf and beat_cnt clear.
- Latency: out_valid asserts on the cycle after the edge that accepts the COUNT-th beat.
- Throughput:
  - Minimum one idle cycle per frame, because HOLD does not accept beats.
  - Peak rate is COUNT beats per COUNT+1 cycles under continuous out_ready.
- Backpressure: out_valid remains high and out_sum and out_ovf remain unchanged until out_ready. in_valid beats presented during HOLD are not accepted.
- abort (sampled at edge, any state):
  - Next state is IDLE; acc, ovf and beat_cnt go to 0; out_valid goes to 0.
  - abort overrides out_ready and any simultaneous in_valid. in_ready is 0 during abort, so the beat is not consumed.
- Out-of-range parameters are not supported. The bench checks only legal values.

Test Plan (WIDTH=4, COUNT=4, ACC_W=6):
- Basic frame:
  - Stimulus: beats (3,0),(1,0),(15,0),(9,1) back-to-back, out_ready=1.
  - Required: out_valid=1 one cycle after 4th accept, out_sum=29, out_ovf=0, beat_cnt=4; IDLE next cycle.
- Overflow:
  - Stimulus: four beats (15,1).
  - Required: total 64, so out_sum=0 and out_ovf=1. Next frame (1,0)x4 gives out_sum=4, out_ovf=0.
- Backpressure:
  - Stimulus: complete a frame of (2,0)x4, hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: out_valid=1, out_sum=8 stable, in_ready=0, no beats consumed. Raise out_ready, then IDLE and in_ready=1 next cycle.
- Gapped input:
  - Stimulus: in_valid pattern 1,0,1,1,0,1 with in_a=5, cin=0.
  - Required: only 4 accepts counted, beat_cnt steps 1,1,2,3,3,4, out_sum=20.
- Abort:
  - Stimulus: after beats (7,0),(7,0), assert abort together with in_valid=1 (in_a=9).
  - Required: beat not taken, beat_cnt=0, acc=0. Then frame 1,2,3,4 gives out_sum=10.
- Async reset:
  - Stimulus: drop rst_n mid-frame between clock edges.
  - Required: out_valid, out_sum, out_ovf and beat_cnt go to 0 immediately. After release, frame (4,0)x4 gives out_sum=16.
